// File: rtl/sc_counter_pkg.sv
// -----------------------------------------------------------------------------
// sc_counter_pkg
// Shared definitions for the stochastic-number counter bank:
//   - mode_e     : count direction (MODE_UP / MODE_DOWN)
//   - ch_width() : width of the channel-select field for a given channel count
// -----------------------------------------------------------------------------
package sc_counter_pkg;

  // Count direction of one channel.
  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

  // Width of cfg_ch: never below one bit, so a single-channel bank still has a
  // real select port.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/sc_counter_chan.sv
// -----------------------------------------------------------------------------
// sc_counter_chan
// One modulo counter channel: count, bound, mode and terminal-count registers.
//   clk, rst      : clock, asynchronous active-high reset
//   enable_i      : step request
//   restart_i     : synchronous restart (beats enable)
//   cfg_we_i      : local config write enable (already decoded by the bank)
//   cfg_bound_i   : new bound value
//   cfg_mode_i    : new direction (0 up, 1 down)
//   count_o       : registered count
//   tc_o          : registered terminal-count pulse, high when count_o shows
//                   the freshly wrapped value
// -----------------------------------------------------------------------------
module sc_counter_chan
  import sc_counter_pkg::*;
#(
  parameter int N     = 10,
  parameter int BOUND = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable_i,
  input  logic         restart_i,
  input  logic         cfg_we_i,
  input  logic [N-1:0] cfg_bound_i,
  input  logic         cfg_mode_i,
  output logic [N-1:0] count_o,
  output logic         tc_o
);

  localparam logic [N-1:0] BOUND_N = N'(BOUND);
  localparam logic [N-1:0] ZERO_N  = N'(0);
  localparam logic [N-1:0] ONE_N   = N'(1);

  logic [N-1:0] count_q, count_d;
  logic [N-1:0] bound_q, bound_d;
  mode_e        mode_q,  mode_d;
  logic         tc_q,    tc_d;

  // Next-state for count/tc from the current bound and mode; config values
  // written this cycle only take effect from the next cycle.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (restart_i) begin
      case (mode_q)
        MODE_UP:   count_d = ZERO_N;
        MODE_DOWN: count_d = bound_q;
        default:   count_d = ZERO_N;
      endcase
    end else if (enable_i) begin
      case (mode_q)
        MODE_UP: begin
          // >= rather than == so a shrunken bound wraps on the next step, and
          // bound = all-ones wraps without relying on adder overflow.
          if (count_q >= bound_q) begin
            count_d = ZERO_N;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + ONE_N;
          end
        end
        MODE_DOWN: begin
          if ((count_q == ZERO_N) || (count_q > bound_q)) begin
            count_d = bound_q;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q - ONE_N;
          end
        end
        default: begin
          count_d = ZERO_N;
        end
      endcase
    end else begin
      count_d = count_q;
    end
  end

  // Next-state for bound/mode: plain load on a decoded write.
  always_comb begin
    bound_d = bound_q;
    mode_d  = mode_q;
    if (cfg_we_i) begin
      bound_d = cfg_bound_i;
      mode_d  = mode_e'(cfg_mode_i);
    end else begin
      bound_d = bound_q;
      mode_d  = mode_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= ZERO_N;
      bound_q <= BOUND_N;
      mode_q  <= MODE_UP;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      bound_q <= bound_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;

endmodule

// File: rtl/sc_counter_bank.sv
// -----------------------------------------------------------------------------
// sc_counter_bank
// NCH independent runtime-configurable modulo counters feeding comparator SNGs.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : per-channel step request
//   restart    : per-channel synchronous restart
//   cfg_we     : config write strobe (shared)
//   cfg_ch     : target channel; values >= NCH are dropped
//   cfg_bound  : new bound
//   cfg_mode   : new direction (0 up, 1 down)
//   out        : channel i count at [i*N +: N], bit-reversed when REVERSE = 1
//   tc         : per-channel terminal-count pulse
// Outputs are wires straight off channel registers (no input-to-output path).
// -----------------------------------------------------------------------------
module sc_counter_bank
  import sc_counter_pkg::*;
#(
  parameter int N       = 10,
  parameter int NCH     = 4,
  parameter int BOUND   = 1000,
  parameter int REVERSE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             enable,
  input  logic [NCH-1:0]             restart,
  input  logic                       cfg_we,
  input  logic [ch_width(NCH)-1:0]   cfg_ch,
  input  logic [N-1:0]               cfg_bound,
  input  logic                       cfg_mode,
  output logic [NCH*N-1:0]           out,
  output logic [NCH-1:0]             tc
);

  localparam int CW = ch_width(NCH);

  logic [NCH-1:0] we_s;
  logic [N-1:0]   count_s [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    // Out-of-range cfg_ch matches no channel, so such a write is dropped.
    assign we_s[i] = cfg_we & (cfg_ch == CW'(i));

    sc_counter_chan #(
      .N     (N),
      .BOUND (BOUND)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .enable_i    (enable[i]),
      .restart_i   (restart[i]),
      .cfg_we_i    (we_s[i]),
      .cfg_bound_i (cfg_bound),
      .cfg_mode_i  (cfg_mode),
      .count_o     (count_s[i]),
      .tc_o        (tc[i])
    );

    for (genvar k = 0; k < N; k++) begin : g_bit
      if (REVERSE != 0) begin : g_rev
        assign out[i*N + k] = count_s[i][N-1-k];
      end else begin : g_fwd
        assign out[i*N + k] = count_s[i][k];
      end
    end
  end

endmodule
